// File: rtl/cycle_sequencer_pkg.sv
// Shared definitions for the cycle sequencer and the instruction decoder.
package cycle_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_RST  = 2'd0,
      ST_EXEC = 2'd1,
      ST_HALT = 2'd2
   } seq_state_t;

   // Pending request flags, ordered by acknowledge priority (rst highest).
   typedef struct packed {
      logic rst;
      logic nmi;
      logic irq;
   } req_flags_t;

   localparam logic [7:0] OP_BRK     = 8'h00;
   localparam int         WDOG_LIMIT = 4;
   localparam int         WDOG_W     = 3;
   localparam logic [2:0] CYCLE_MAX  = 3'd7;

   // Returns a one-hot mask naming the single highest-priority pending flag.
   function automatic req_flags_t ack_select(input req_flags_t pending);
      req_flags_t mask;
      mask = '0;
      if (pending.rst) begin
         mask.rst = 1'b1;
      end else if (pending.nmi) begin
         mask.nmi = 1'b1;
      end else if (pending.irq) begin
         mask.irq = 1'b1;
      end
      return mask;
   endfunction

endpackage

// File: rtl/cycle_sequencer_edge_det.sv
// Falling-edge detector: one registered sample, pulse when the input drops.
module edge_det (
   input  logic clk,
   input  logic clr,
   input  logic sig,
   output logic fall
);

   logic sample_q;
   logic sample_d;

   // Next sample is simply the current input level.
   always_comb begin
      sample_d = sig;
   end

   // Sample register idles high so a line held low through reset still reports an edge.
   always_ff @(posedge clk) begin
      if (!clr) begin
         sample_q <= 1'b1;
      end else begin
         sample_q <= sample_d;
      end
   end

   assign fall = sample_q & ~sig;

endmodule

// File: rtl/cycle_sequencer.sv
// Instruction cycle sequencer: tracks cycle index, instruction register,
// pending reset/nmi/irq requests and a watchdog for undecoded opcodes.
module cycle_sequencer
   import cycle_sequencer_pkg::*;
(
   input  logic       clk,
   input  logic       clr,
   input  logic       rdy,
   input  logic [7:0] din,
   input  logic       irq_n,
   input  logic       nmi_n,
   input  logic       iflag,
   input  logic       icyc,
   input  logic       rcyc,
   input  logic       scyc,
   input  logic       sinst,
   output logic [2:0] cycle,
   output logic [7:0] inst,
   output logic       rstreq,
   output logic       irqreq,
   output logic       nmireq,
   output logic       halt
);

   localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_LIMIT - 1);

   seq_state_t        state_q, state_d;
   logic [2:0]        cycle_q, cycle_d;
   logic [7:0]        inst_q, inst_d;
   logic [WDOG_W-1:0] wdog_q, wdog_d;
   logic              halt_q, halt_d;
   logic              rstreq_q, rstreq_d;
   logic              nmireq_q, nmireq_d;
   logic              irqreq_q, irqreq_d;
   logic              nmi_fall;
   logic              ack_valid;
   logic              take_int;
   req_flags_t        pending;
   req_flags_t        ack_mask;

   edge_det u_nmi_edge (
      .clk  (clk),
      .clr  (clr),
      .sig  (nmi_n),
      .fall (nmi_fall)
   );

   // Request flags: nmi latches on edges, irq follows the line, sinst retires the top one.
   always_comb begin
      pending   = '{rst: rstreq_q, nmi: nmireq_q, irq: irqreq_q};
      ack_valid = sinst && rdy && (state_q == ST_EXEC);
      ack_mask  = ack_valid ? ack_select(pending) : '0;
      rstreq_d  = rstreq_q && !ack_mask.rst;
      nmireq_d  = nmi_fall || (nmireq_q && !ack_mask.nmi);
      irqreq_d  = !irq_n && !ack_mask.irq;
   end

   // Next-state and cycle/instruction update; rdy low freezes everything but clears the
   // watchdog so it only trips on strobe-free cycles that are also consecutive.
   always_comb begin
      state_d  = state_q;
      cycle_d  = cycle_q;
      inst_d   = inst_q;
      wdog_d   = '0;
      take_int = rstreq_q || nmireq_q || (irqreq_q && !iflag);
      if (rdy) begin
         case (state_q)
            ST_RST: begin
               state_d = ST_EXEC;
               cycle_d = 3'd0;
               inst_d  = OP_BRK;
            end
            ST_EXEC: begin
               if (rcyc) begin
                  cycle_d = 3'd0;
                  inst_d  = take_int ? OP_BRK : din;
               end else if (scyc) begin
                  cycle_d = cycle_q;
               end else if (icyc) begin
                  if (cycle_q == CYCLE_MAX) begin
                     state_d = ST_HALT;
                  end else begin
                     cycle_d = cycle_q + 3'd1;
                  end
               end else if (wdog_q == WDOG_LAST) begin
                  state_d = ST_HALT;
               end else begin
                  wdog_d = wdog_q + 1'b1;
               end
            end
            ST_HALT: begin
               state_d = ST_HALT;
            end
            default: begin
               state_d = ST_HALT;
            end
         endcase
      end
      halt_d = (state_d == ST_HALT);
   end

   // Sequencer registers; clr overrides any strobe seen on the same edge.
   always_ff @(posedge clk) begin
      if (!clr) begin
         state_q <= ST_RST;
         cycle_q <= 3'd0;
         inst_q  <= OP_BRK;
         wdog_q  <= '0;
         halt_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cycle_q <= cycle_d;
         inst_q  <= inst_d;
         wdog_q  <= wdog_d;
         halt_q  <= halt_d;
      end
   end

   // Request flag registers; reset leaves a reset request pending for the decoder.
   always_ff @(posedge clk) begin
      if (!clr) begin
         rstreq_q <= 1'b1;
         nmireq_q <= 1'b0;
         irqreq_q <= 1'b0;
      end else begin
         rstreq_q <= rstreq_d;
         nmireq_q <= nmireq_d;
         irqreq_q <= irqreq_d;
      end
   end

   assign cycle  = cycle_q;
   assign inst   = inst_q;
   assign rstreq = rstreq_q;
   assign nmireq = nmireq_q;
   assign irqreq = irqreq_q;
   assign halt   = halt_q;

endmodule

// File: tb/tb_cycle_sequencer.sv
// Directed and randomized bench for cycle_sequencer with a behavioural model.
module tb_cycle_sequencer;

   logic       clk = 1'b0;
   logic       clr, rdy, irq_n, nmi_n, iflag;
   logic       icyc, rcyc, scyc, sinst;
   logic [7:0] din;
   logic [2:0] cycle;
   logic [7:0] inst;
   logic       rstreq, irqreq, nmireq, halt;

   int checks = 0;
   int errors = 0;

   // Behavioural model: mode 0 = coming out of reset, 1 = running, 2 = stopped.
   int         m_mode;
   int         m_cycle;
   int         m_idle;
   logic [7:0] m_inst;
   bit         m_rst, m_nmi, m_irq, m_nmi_prev;

   cycle_sequencer dut (
      .clk    (clk),
      .clr    (clr),
      .rdy    (rdy),
      .din    (din),
      .irq_n  (irq_n),
      .nmi_n  (nmi_n),
      .iflag  (iflag),
      .icyc   (icyc),
      .rcyc   (rcyc),
      .scyc   (scyc),
      .sinst  (sinst),
      .cycle  (cycle),
      .inst   (inst),
      .rstreq (rstreq),
      .irqreq (irqreq),
      .nmireq (nmireq),
      .halt   (halt)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Advance the model by one clock edge using the inputs presented at that edge.
   task automatic modelEdge();
      bit fell, ack, n_rst, n_nmi, n_irq, want_int;
      if (!clr) begin
         m_mode = 0; m_cycle = 0; m_inst = 8'h00; m_idle = 0;
         m_rst = 1; m_nmi = 0; m_irq = 0; m_nmi_prev = 1;
         return;
      end
      fell = m_nmi_prev && !nmi_n;
      m_nmi_prev = nmi_n;
      ack = sinst && rdy && (m_mode == 1);
      n_rst = m_rst; n_nmi = m_nmi; n_irq = !irq_n;
      if (ack) begin
         if (m_rst) n_rst = 0;
         else if (m_nmi) n_nmi = 0;
         else if (m_irq) n_irq = 0;
      end
      if (fell) n_nmi = 1;
      want_int = m_rst || m_nmi || (m_irq && !iflag);
      if (!rdy) begin
         m_idle = 0;
      end else if (m_mode == 0) begin
         m_mode = 1;
      end else if (m_mode == 1) begin
         if (rcyc) begin
            m_cycle = 0; m_idle = 0;
            m_inst = want_int ? 8'h00 : din;
         end else if (scyc) begin
            m_idle = 0;
         end else if (icyc) begin
            m_idle = 0;
            if (m_cycle == 7) m_mode = 2;
            else m_cycle = m_cycle + 1;
         end else begin
            m_idle = m_idle + 1;
            if (m_idle >= 4) m_mode = 2;
         end
      end
      m_rst = n_rst; m_nmi = n_nmi; m_irq = n_irq;
   endtask

   task automatic check1(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("[TB] FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic checkOutput(input string tag);
      check1({tag, ".cycle"},  {5'd0, cycle},  8'(m_cycle));
      check1({tag, ".inst"},   inst,           m_inst);
      check1({tag, ".rstreq"}, {7'd0, rstreq}, {7'd0, m_rst});
      check1({tag, ".nmireq"}, {7'd0, nmireq}, {7'd0, m_nmi});
      check1({tag, ".irqreq"}, {7'd0, irqreq}, {7'd0, m_irq});
      check1({tag, ".halt"},   {7'd0, halt},   {7'd0, (m_mode == 2)});
   endtask

   task automatic applyStimulus(input string tag);
      @(posedge clk);
      modelEdge();
      #1;
      checkOutput(tag);
   endtask

   task automatic clearStrobes();
      icyc = 0; rcyc = 0; scyc = 0; sinst = 0;
   endtask

   // Directed scenarios followed by randomized traffic, all in one linear sequence.
   initial begin
      clr = 0; rdy = 1; din = 8'h00; irq_n = 1; nmi_n = 1; iflag = 0;
      clearStrobes();
      m_nmi_prev = 1;

      $display("[TB] reset and release");
      applyStimulus("reset0");
      applyStimulus("reset1");
      check1("reset.halt", {7'd0, halt}, 8'h00);
      check1("reset.rstreq", {7'd0, rstreq}, 8'h01);
      clr = 1;
      applyStimulus("release1");
      applyStimulus("release2");
      check1("release.inst", inst, 8'h00);
      check1("release.cycle", {5'd0, cycle}, 8'h00);
      sinst = 1;
      applyStimulus("ack_rst");
      check1("ack_rst.rstreq", {7'd0, rstreq}, 8'h00);

      $display("[TB] fetch and count");
      clearStrobes(); rcyc = 1; din = 8'h69;
      applyStimulus("fetch69");
      check1("fetch69.inst", inst, 8'h69);
      clearStrobes(); icyc = 1;
      for (int i = 0; i < 3; i++) applyStimulus("icyc");
      check1("icyc3.cycle", {5'd0, cycle}, 8'h03);
      clearStrobes(); rcyc = 1; din = 8'h6D;
      applyStimulus("fetch6D");
      check1("fetch6D.inst", inst, 8'h6D);

      $display("[TB] interrupts");
      clearStrobes(); icyc = 1; nmi_n = 0; irq_n = 0; iflag = 0;
      applyStimulus("nmi_edge");
      clearStrobes(); scyc = 1; nmi_n = 1;
      applyStimulus("nmi_hold");
      check1("int.nmireq", {7'd0, nmireq}, 8'h01);
      check1("int.irqreq", {7'd0, irqreq}, 8'h01);
      clearStrobes(); rcyc = 1; din = 8'hAA;
      applyStimulus("int_fetch");
      check1("int_fetch.inst", inst, 8'h00);
      clearStrobes(); scyc = 1; sinst = 1;
      applyStimulus("ack_nmi");
      check1("ack_nmi.nmireq", {7'd0, nmireq}, 8'h00);
      check1("ack_nmi.irqreq", {7'd0, irqreq}, 8'h01);
      applyStimulus("ack_irq");
      check1("ack_irq.irqreq", {7'd0, irqreq}, 8'h00);
      clearStrobes(); scyc = 1; irq_n = 0; iflag = 1;
      applyStimulus("irq_masked_set");
      clearStrobes(); rcyc = 1; din = 8'h65;
      applyStimulus("irq_masked_fetch");
      check1("masked.inst", inst, 8'h65);
      check1("masked.irqreq", {7'd0, irqreq}, 8'h01);
      irq_n = 1; iflag = 0; din = 8'h11;
      applyStimulus("fetch11");

      $display("[TB] cycle overflow");
      clearStrobes(); icyc = 1;
      for (int i = 0; i < 8; i++) applyStimulus("icyc_run");
      check1("overflow.halt", {7'd0, halt}, 8'h01);
      check1("overflow.cycle", {5'd0, cycle}, 8'h07);
      applyStimulus("halt_hold");
      clearStrobes(); clr = 0;
      applyStimulus("halt_clr");
      check1("halt_clr.halt", {7'd0, halt}, 8'h00);

      $display("[TB] watchdog");
      clr = 1;
      applyStimulus("wd_enter");
      for (int i = 0; i < 3; i++) applyStimulus("wd_idle");
      check1("wd3.halt", {7'd0, halt}, 8'h00);
      applyStimulus("wd_trip");
      check1("wd4.halt", {7'd0, halt}, 8'h01);
      clr = 0;
      applyStimulus("wd_reset");
      clr = 1;
      applyStimulus("wd_enter2");
      for (int i = 0; i < 10; i++) begin
         rdy = (i % 2 == 0);
         applyStimulus("wd_toggle");
      end
      check1("wd_toggle.halt", {7'd0, halt}, 8'h00);
      rdy = 1;
      for (int i = 0; i < 3; i++) applyStimulus("wd_idle2");
      check1("wd_idle2.halt", {7'd0, halt}, 8'h00);
      applyStimulus("wd_trip2");
      check1("wd_trip2.halt", {7'd0, halt}, 8'h01);

      $display("[TB] randomized traffic");
      clr = 0;
      applyStimulus("rand_reset");
      for (int i = 0; i < 600; i++) begin
         clr   = ($urandom_range(0, 39) != 0);
         rdy   = ($urandom_range(0, 3) != 0);
         din   = 8'($urandom);
         iflag = 1'($urandom);
         irq_n = ($urandom_range(0, 4) != 0);
         if ($urandom_range(0, 5) == 0) nmi_n = ~nmi_n;
         rcyc  = ($urandom_range(0, 4) == 0);
         scyc  = ($urandom_range(0, 4) == 0);
         icyc  = ($urandom_range(0, 1) == 0);
         sinst = ($urandom_range(0, 3) == 0);
         applyStimulus("random");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
